// File: rtl/status_flag_unit.sv
// Execute-stage ALU and {z,c,n,v} status register.
// Provides a forwarded flag view for dependent conditional instructions.
module status_flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [3:0]       exe_cmd,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             s_bit,
  input  logic             cond_pass,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       sr,
  output logic [3:0]       sr_next,
  output logic             sr_updated
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [3:0]       sr_q, sr_d;
  logic             upd_q, upd_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] op2;
  logic             cin;
  logic             arith;
  logic             is_sub;
  logic             rec;
  logic             c_c, v_c;
  logic             msb_a, msb_b, msb_r;
  logic [3:0]       cand;
  logic             upd;

  always_comb begin
    arith  = 1'b0;
    is_sub = 1'b0;
    cin    = 1'b0;
    rec    = 1'b1;
    res    = '0;
    unique case (exe_cmd)
      CMD_MOV: res = op_b;
      CMD_MVN: res = ~op_b;
      CMD_AND: res = op_a & op_b;
      CMD_ORR: res = op_a | op_b;
      CMD_EOR: res = op_a ^ op_b;
      CMD_ADD: arith = 1'b1;
      CMD_ADC: begin
        arith = 1'b1;
        cin   = sr_q[2];
      end
      CMD_SUB: begin
        arith  = 1'b1;
        is_sub = 1'b1;
        cin    = 1'b1;
      end
      CMD_SBC: begin
        arith  = 1'b1;
        is_sub = 1'b1;
        cin    = sr_q[2];
      end
      default: rec = 1'b0;
    endcase
    // Carry-in comes from the registered C, never from sr_next.
    op2 = is_sub ? ~op_b : op_b;
    sum = {1'b0, op_a} + {1'b0, op2}
        + {{WIDTH{1'b0}}, cin};
    if (arith) res = sum[WIDTH-1:0];
  end

  assign msb_a = op_a[WIDTH-1];
  assign msb_b = op_b[WIDTH-1];
  assign msb_r = res[WIDTH-1];

  always_comb begin
    c_c = sr_q[2];
    v_c = sr_q[0];
    if (arith) begin
      c_c = sum[WIDTH];
      if (is_sub)
        v_c = (msb_a != msb_b) && (msb_r != msb_a);
      else
        v_c = (msb_a == msb_b) && (msb_r != msb_a);
    end
  end

  assign cand = {(res == '0), c_c, msb_r, v_c};

  assign upd = valid && s_bit && cond_pass && rec
            && !stall && !flush;

  always_comb begin
    sr_d  = sr_q;
    upd_d = upd;
    if (upd) sr_d = cand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= 4'b0000;
      upd_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      upd_q <= upd_d;
    end
  end

  assign result     = res;
  assign sr         = sr_q;
  assign sr_next    = upd ? cand : sr_q;
  assign sr_updated = upd_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// Self-checking bench for status_flag_unit.
// Directed plan cases plus random ops against an arithmetic flag model.
module tb_status_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [3:0]  exe_cmd;
  logic [31:0] op_a, op_b;
  logic        s_bit, cond_pass, stall, flush;
  logic [31:0] result;
  logic [3:0]  sr, sr_next;
  logic        sr_updated;

  int n_chk = 0;
  int n_pass = 0;

  logic [3:0] m_sr = 4'b0000;
  logic       m_upd = 1'b0;

  status_flag_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid),
    .exe_cmd(exe_cmd), .op_a(op_a), .op_b(op_b),
    .s_bit(s_bit), .cond_pass(cond_pass),
    .stall(stall), .flush(flush),
    .result(result), .sr(sr), .sr_next(sr_next),
    .sr_updated(sr_updated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, obs, exp);
  endtask

  function automatic bit in_range(input longint s);
    return (s <= 64'sd2147483647) && (s >= -64'sd2147483648);
  endfunction

  // Flags from signed/unsigned arithmetic, not from bit formulas.
  task automatic model(input logic [3:0] cmd,
                       input logic [31:0] a, b,
                       input logic [3:0] f,
                       output logic [31:0] r,
                       output logic [3:0] cand,
                       output bit rec);
    longint ua, ub, sa, sb, ext, sres, cin, bin;
    bit cc, vv;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cc = f[2];
    vv = f[0];
    rec = 1'b1;
    r = 32'h0;
    case (cmd)
      4'd1: r = b;
      4'd9: r = ~b;
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      4'd2, 4'd3: begin
        cin  = (cmd == 4'd3) ? longint'(f[2]) : 0;
        ext  = ua + ub + cin;
        r    = ext[31:0];
        cc   = ext >= 64'h1_0000_0000;
        sres = sa + sb + cin;
        vv   = !in_range(sres);
      end
      4'd4, 4'd5: begin
        bin  = (cmd == 4'd4) ? 0 : 1 - longint'(f[2]);
        ext  = ua - ub - bin;
        r    = ext[31:0];
        cc   = ua >= ub + bin;
        sres = sa - sb - bin;
        vv   = !in_range(sres);
      end
      default: rec = 1'b0;
    endcase
    cand = {r == 32'h0, cc, r[31], vv};
  endtask

  task automatic run_op(input logic [3:0] cmd,
                        input logic [31:0] a, b,
                        input bit s, cp, v, st, fl);
    logic [31:0] r;
    logic [3:0] cand;
    bit rec, upd;
    @(negedge clk);
    exe_cmd = cmd; op_a = a; op_b = b;
    s_bit = s; cond_pass = cp; valid = v;
    stall = st; flush = fl;
    #1;
    model(cmd, a, b, m_sr, r, cand, rec);
    upd = v && s && cp && rec && !st && !fl;
    chk("result", result, r);
    chk("sr_next", {28'h0, sr_next},
        {28'h0, upd ? cand : m_sr});
    @(posedge clk);
    #1;
    if (upd) m_sr = cand;
    m_upd = upd;
    chk("sr", {28'h0, sr}, {28'h0, m_sr});
    chk("sr_updated", {31'h0, sr_updated}, {31'h0, m_upd});
  endtask

  logic [3:0] cmds [12] = '{4'd1, 4'd9, 4'd2, 4'd3,
    4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0, 4'd15, 4'd10};
  logic [31:0] edges [6] = '{32'h0, 32'h1, 32'h7FFFFFFF,
    32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFE};

  function automatic logic [31:0] pick_op();
    if ($urandom_range(3) == 0)
      return edges[$urandom_range(5)];
    return $urandom;
  endfunction

  initial begin
    rst_n = 1'b0;
    valid = 0; exe_cmd = 0; op_a = 0; op_b = 0;
    s_bit = 0; cond_pass = 0; stall = 0; flush = 0;
    #12;
    chk("reset_sr", {28'h0, sr}, 32'h0);
    chk("reset_upd", {31'h0, sr_updated}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd2, 32'h7FFFFFFF, 32'h1, 1, 1, 1, 0, 0);
    chk("plan_add_sr", {28'h0, sr}, 32'h3);
    chk("plan_add_res", result, 32'h80000000);
    run_op(4'd4, 32'd5, 32'd5, 1, 1, 1, 0, 0);
    chk("plan_cmp_eq", {28'h0, sr}, 32'hC);
    run_op(4'd4, 32'd3, 32'd5, 1, 1, 1, 0, 0);
    chk("plan_cmp_lt", {28'h0, sr}, 32'h2);
    run_op(4'd4, 32'd5, 32'd5, 1, 1, 1, 0, 0);
    run_op(4'd3, 32'hFFFFFFFF, 32'h0, 1, 1, 1, 0, 0);
    chk("plan_adc", {28'h0, sr}, 32'hC);

    // Mid-cycle reset must clear state without a clock edge.
    run_op(4'd2, 32'h7FFFFFFF, 32'h1, 1, 1, 1, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sr", {28'h0, sr}, 32'h0);
    chk("async_rst_upd", {31'h0, sr_updated}, 32'h0);
    m_sr = 4'b0000;
    m_upd = 1'b0;
    valid = 0;
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd4, 32'd3, 32'd5, 1, 1, 1, 0, 0);
    run_op(4'd2, 32'hFFFFFFFF, 32'h1, 0, 1, 1, 0, 0);
    run_op(4'd2, 32'hFFFFFFFF, 32'h1, 1, 0, 1, 0, 0);
    run_op(4'd2, 32'hFFFFFFFF, 32'h1, 1, 1, 1, 1, 0);
    run_op(4'd2, 32'hFFFFFFFF, 32'h1, 1, 1, 1, 1, 0);
    run_op(4'd2, 32'hFFFFFFFF, 32'h1, 1, 1, 1, 0, 1);
    run_op(4'd2, 32'hFFFFFFFF, 32'h1, 1, 1, 1, 1, 1);
    run_op(4'd2, 32'hFFFFFFFF, 32'h1, 1, 1, 0, 0, 0);
    chk("plan_gated", {28'h0, sr}, 32'h2);
    run_op(4'd2, 32'hFFFFFFFF, 32'h1, 1, 1, 1, 0, 0);
    chk("plan_wrap", {28'h0, sr}, 32'hC);

    run_op(4'd4, 32'h80000000, 32'h1, 1, 1, 1, 0, 0);
    chk("plan_setup_0101", {28'h0, sr}, 32'h5);
    run_op(4'd6, 32'hF0F0F0F0, 32'h0F0F0F0F, 1, 1, 1, 0, 0);
    chk("plan_and", {28'h0, sr}, 32'hD);
    run_op(4'd15, 32'h12345678, 32'h1, 1, 1, 1, 0, 0);
    chk("plan_bad_cmd", {28'h0, sr}, 32'hD);

    for (int i = 0; i < 400; i++) begin
      run_op(cmds[$urandom_range(11)], pick_op(), pick_op(),
             $urandom_range(3) != 0, $urandom_range(4) != 0,
             $urandom_range(5) != 0, $urandom_range(6) == 0,
             $urandom_range(8) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
